// File: rtl/shift_sequencer.sv
// shift_sequencer: multi-cycle 32-bit shift/rotate unit, one bit per SHIFT cycle.
// Define SHIFT_FAST4_EN to apply four bits per cycle while at least four remain.
module shift_sequencer #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [4:0]       shamt,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] data, data_n;
    logic [4:0] cnt, cnt_n;
    logic [1:0] op_q, op_n;

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] d, input logic [1:0] o);
        return o == 2'b00 ? {d[WIDTH-2:0], 1'b0} :
               o == 2'b01 ? {1'b0, d[WIDTH-1:1]} :
               o == 2'b10 ? {d[WIDTH-1], d[WIDTH-1:1]} : {d[WIDTH-2:0], d[WIDTH-1]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            data  <= '0;
            cnt   <= '0;
            op_q  <= 2'b00;
        end else begin
            state <= state_n;
            data  <= data_n;
            cnt   <= cnt_n;
            op_q  <= op_n;
        end
    end

    always_comb begin
        state_n = state;
        data_n  = data;
        cnt_n   = cnt;
        op_n    = op_q;
        case (state)
            IDLE: if (start) begin
                data_n  = a;
                cnt_n   = shamt;
                op_n    = op;
                state_n = shamt == 5'd0 ? DONE : SHIFT;
            end
`ifdef SHIFT_FAST4_EN
            SHIFT: begin
                data_n  = cnt >= 5'd4 ? step(step(step(step(data, op_q), op_q), op_q), op_q)
                                      : step(data, op_q);
                cnt_n   = cnt >= 5'd4 ? cnt - 5'd4 : cnt - 5'd1;
                state_n = cnt_n == 5'd0 ? DONE : SHIFT;
            end
`else
            SHIFT: begin
                data_n  = step(data, op_q);
                cnt_n   = cnt - 5'd1;
                state_n = cnt == 5'd1 ? DONE : SHIFT;
            end
`endif
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign result = data;
    assign busy   = state != IDLE;
    assign done   = state == DONE;
endmodule
